// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Adaptive four-approach signal scheduler. Consumes debounced sensor bits
// (presence + long queue per approach). It grants green to one approach at a
// time, round-robin over the approaches that have demand. It extends green
// while traffic flows, up to a limit, then sequences yellow and all-red
// clearance. All durations are counted in `tick` pulses, not clock cycles.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   tick         in   one-cycle timebase enable; state only advances on it
//   sensor[7:0]  in   [2k] = approach k presence, [2k+1] = approach k long queue
//   lights[7:0]  out  [2k+1:2k] = approach k lamp: 00 red, 01 yellow, 10 green
//   active_dir   out  approach currently or most recently granted
//   req_pending  out  latched demand per approach
//   phase_change out  one-cycle pulse on entry to GREEN
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
   parameter int MIN_GREEN    = 5,
   parameter int MAX_GREEN    = 15,
   parameter int EXT_LONG     = 5,
   parameter int YELLOW_TIME  = 3,
   parameter int ALL_RED_TIME = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [7:0] sensor,
   output logic [7:0] lights,
   output logic [1:0] active_dir,
   output logic [3:0] req_pending,
   output logic       phase_change
);

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2
   } state_t;

   state_t     state_reg,  state_next;
   logic [4:0] e_reg,      e_next;
   logic [1:0] dir_reg,    dir_next;
   logic [3:0] req_reg,    req_next;
   logic [7:0] lights_reg, lights_next;
   logic       pc_reg,     pc_next;

   logic [3:0] presence;
   logic [3:0] long_queue;
   logic [3:0] dir_onehot;
   logic [5:0] n;
   logic [4:0] e_inc;
   logic [5:0] limit;
   logic [1:0] grant_dir;
   logic [1:0] cand;
   logic       found;
   logic       grant;

   genvar gi;

   // Split the sensor word into per-approach presence / long-queue bits.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sensor
         assign presence[gi]   = sensor[2*gi];
         assign long_queue[gi] = sensor[2*gi+1];
      end
   endgenerate

   assign dir_onehot = 4'b0001 << dir_reg;

   // n is one bit wider than e so that n = 32 (e saturated) compares correctly.
   assign n     = {1'b0, e_reg} + 6'd1;
   assign e_inc = (e_reg == 5'd31) ? 5'd31 : e_reg + 5'd1;
   assign limit = long_queue[dir_reg] ? 6'(MAX_GREEN + EXT_LONG) : 6'(MAX_GREEN);

   // Round-robin search starting at active_dir+1. The last candidate (i=4)
   // wraps to active_dir itself. With no demand the rotation simply advances.
   always_comb begin
      found     = 1'b0;
      grant_dir = dir_reg + 2'd1;
      cand      = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = dir_reg + 2'(i);
         if (!found && req_reg[cand]) begin
            found     = 1'b1;
            grant_dir = cand;
         end
      end
   end

   // Next-state logic. Decisions are taken only on tick cycles and use the
   // registered requests, so a request latched this cycle waits one tick.
   always_comb begin
      state_next = state_reg;
      e_next     = e_reg;
      dir_next   = dir_reg;
      pc_next    = 1'b0;
      grant      = 1'b0;
      if (tick) begin
         case (state_reg)
            ST_ALL_RED: begin
               if (n == 6'(ALL_RED_TIME)) begin
                  state_next = ST_GREEN;
                  e_next     = 5'd0;
                  dir_next   = grant_dir;
                  pc_next    = 1'b1;
                  grant      = 1'b1;
               end else begin
                  e_next = e_inc;
               end
            end
            ST_GREEN: begin
               // Leave only when contested. Gap-out happens when flow stops;
               // max-out happens at the (possibly extended) limit.
               if ((n >= 6'(MIN_GREEN)) && (|(req_reg & ~dir_onehot)) &&
                   (!presence[dir_reg] || (n >= limit))) begin
                  state_next = ST_YELLOW;
                  e_next     = 5'd0;
               end else begin
                  e_next = e_inc;
               end
            end
            ST_YELLOW: begin
               if (n == 6'(YELLOW_TIME)) begin
                  state_next = ST_ALL_RED;
                  e_next     = 5'd0;
               end else begin
                  e_next = e_inc;
               end
            end
            default: begin
               state_next = ST_ALL_RED;
               e_next     = 5'd0;
            end
         endcase
      end
   end

   // Request latch runs every cycle regardless of tick. A grant clears the
   // bit and beats a simultaneous set; the green approach never latches.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_req
         assign req_next[gi] =
            (grant && (grant_dir == 2'(gi)))                    ? 1'b0 :
            ((state_reg == ST_GREEN) && (dir_reg == 2'(gi)))    ? 1'b0 :
            (req_reg[gi] | presence[gi]);
      end
   endgenerate

   // Lamp word is derived from the next state so that lamps are registered
   // and change on the same edge as the state.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lamp
         assign lights_next[2*gi+1:2*gi] =
            (dir_next != 2'(gi))      ? 2'b00 :
            (state_next == ST_GREEN)  ? 2'b10 :
            (state_next == ST_YELLOW) ? 2'b01 : 2'b00;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_ALL_RED;
         e_reg      <= 5'd0;
         dir_reg    <= 2'd3;
         req_reg    <= 4'd0;
         lights_reg <= 8'h00;
         pc_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         e_reg      <= e_next;
         dir_reg    <= dir_next;
         req_reg    <= req_next;
         lights_reg <= lights_next;
         pc_reg     <= pc_next;
      end
   end

   assign lights       = lights_reg;
   assign active_dir   = dir_reg;
   assign req_pending  = req_reg;
   assign phase_change = pc_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//
// Scenario bench for traffic_phase_scheduler with default parameters.
// Each scenario pushes the expected lamp transitions (lamp word, direction,
// ticks spent in the previous lamp state, phase_change pulse) to a queue
// before driving stimulus. The per-cycle driver pops an entry whenever the
// lamp word changes and compares it.
// -----------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [7:0] sensor = 8'h00;
   logic [7:0] lights;
   logic [1:0] active_dir;
   logic [3:0] req_pending;
   logic       phase_change;

   typedef struct {
      logic [7:0] lights;
      logic [1:0] dir;
      int         dur;
      logic       pc;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad = 0;
   int         tip = 0;
   logic [7:0] prev_lights = 8'h00;

   traffic_phase_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .sensor       (sensor),
      .lights       (lights),
      .active_dir   (active_dir),
      .req_pending  (req_pending),
      .phase_change (phase_change)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] l, input logic [1:0] d, input int du,
                               input logic p);
      exp_t x;
      x.lights = l;
      x.dir    = d;
      x.dur    = du;
      x.pc     = p;
      return x;
   endfunction

   // One clock: drive on the falling edge, sample 1 time unit after the
   // rising edge, and check any lamp transition against the scoreboard.
   task automatic step(input logic t, input logic [7:0] s);
      exp_t x;
      logic exp_pc;
      @(negedge clk);
      tick   = t;
      sensor = s;
      @(posedge clk);
      #1;
      if (t) tip++;
      exp_pc = 1'b0;
      if (lights !== prev_lights) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change lights=%02h was=%02h expected no change",
                     lights, prev_lights);
         end else begin
            x = sb.pop_front();
            exp_pc = x.pc;
            if (lights !== x.lights || active_dir !== x.dir || tip != x.dur) begin
               bad++;
               $display("FAIL transition lights=%02h dir=%0d ticks=%0d expected lights=%02h dir=%0d ticks=%0d",
                        lights, active_dir, tip, x.lights, x.dir, x.dur);
            end else begin
               $display("transition lights=%02h dir=%0d ticks=%0d ok", lights, active_dir, tip);
            end
         end
         prev_lights = lights;
         tip = 0;
      end
      total++;
      if (phase_change !== exp_pc) begin
         bad++;
         $display("FAIL phase_change got=%b expected=%b lights=%02h", phase_change, exp_pc, lights);
      end
   endtask

   task automatic run(input int cnt, input logic t, input logic [7:0] s);
      for (int i = 0; i < cnt; i++) step(t, s);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      tick   = 1'b0;
      sensor = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      prev_lights = 8'h00;
      tip = 0;
   endtask

   task automatic check_empty(input string name);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_pending got=%0d transitions missing expected=0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total += 4;
      if (lights !== 8'h00)     begin bad++; $display("FAIL rst_lights got=%02h expected=00", lights); end
      if (active_dir !== 2'd3)  begin bad++; $display("FAIL rst_dir got=%0d expected=3", active_dir); end
      if (req_pending !== 4'h0) begin bad++; $display("FAIL rst_req got=%h expected=0", req_pending); end
      if (phase_change !== 1'b0) begin bad++; $display("FAIL rst_pc got=%b expected=0", phase_change); end
      $display("reset values lights=%02h dir=%0d req=%h", lights, active_dir, req_pending);
      rst_n = 1'b1;
      sb.delete();
      prev_lights = 8'h00;
      tip = 0;
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      run(60, 1'b1, 8'h00);
      check_empty("rest");
      total++;
      if (lights !== 8'h02 || active_dir !== 2'd0) begin
         bad++;
         $display("FAIL rest_hold lights=%02h dir=%0d expected lights=02 dir=0", lights, active_dir);
      end
   endtask

   task automatic test_gap_out();
      do_reset();
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      sb.push_back(mk(8'h01, 2'd0, 5, 1'b0));
      sb.push_back(mk(8'h00, 2'd0, 3, 1'b0));
      sb.push_back(mk(8'h08, 2'd1, 1, 1'b1));
      step(1'b1, 8'h00);
      step(1'b0, 8'h04);
      run(11, 1'b1, 8'h00);
      check_empty("gap_out");
      total++;
      if (lights !== 8'h08 || active_dir !== 2'd1 || req_pending[1] !== 1'b0) begin
         bad++;
         $display("FAIL gap_out_end lights=%02h dir=%0d req=%h expected lights=08 dir=1 req[1]=0",
                  lights, active_dir, req_pending);
      end
   endtask

   task automatic test_max_out();
      do_reset();
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      sb.push_back(mk(8'h01, 2'd0, 15, 1'b0));
      sb.push_back(mk(8'h00, 2'd0, 3, 1'b0));
      sb.push_back(mk(8'h08, 2'd1, 1, 1'b1));
      run(22, 1'b1, 8'h05);
      check_empty("max_out");
      do_reset();
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      sb.push_back(mk(8'h01, 2'd0, 20, 1'b0));
      sb.push_back(mk(8'h00, 2'd0, 3, 1'b0));
      sb.push_back(mk(8'h08, 2'd1, 1, 1'b1));
      run(27, 1'b1, 8'h07);
      check_empty("max_out_long");
   endtask

   task automatic test_skip();
      do_reset();
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      sb.push_back(mk(8'h01, 2'd0, 5, 1'b0));
      sb.push_back(mk(8'h00, 2'd0, 3, 1'b0));
      sb.push_back(mk(8'h80, 2'd3, 1, 1'b1));
      step(1'b1, 8'h00);
      step(1'b0, 8'h40);
      run(11, 1'b1, 8'h00);
      check_empty("skip");
      total++;
      if (req_pending !== 4'h0) begin
         bad++;
         $display("FAIL skip_req got=%h expected=0", req_pending);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      sb.push_back(mk(8'h01, 2'd0, 5, 1'b0));
      sb.push_back(mk(8'h00, 2'd0, 3, 1'b0));
      sb.push_back(mk(8'h08, 2'd1, 1, 1'b1));
      step(1'b1, 8'h00);
      step(1'b0, 8'h04);
      run(5, 1'b1, 8'h00);
      step(1'b1, 8'h00);
      run(50, 1'b0, 8'h00);
      step(1'b0, 8'h10);
      run(49, 1'b0, 8'h00);
      total++;
      if (lights !== 8'h01 || active_dir !== 2'd0 || req_pending !== 4'b0110) begin
         bad++;
         $display("FAIL freeze_hold lights=%02h dir=%0d req=%h expected lights=01 dir=0 req=6",
                  lights, active_dir, req_pending);
      end
      run(5, 1'b1, 8'h00);
      check_empty("freeze");
      total++;
      if (req_pending !== 4'b0100) begin
         bad++;
         $display("FAIL freeze_req got=%h expected=4", req_pending);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      sb.push_back(mk(8'h02, 2'd0, 1, 1'b1));
      sb.push_back(mk(8'h01, 2'd0, 5, 1'b0));
      step(1'b1, 8'h00);
      step(1'b0, 8'h04);
      run(5, 1'b1, 8'h00);
      step(1'b0, 8'h10);
      step(1'b0, 8'h00);
      check_empty("pre_async");
      total++;
      if (lights !== 8'h01 || req_pending[2] !== 1'b1) begin
         bad++;
         $display("FAIL pre_async lights=%02h req=%h expected lights=01 req[2]=1", lights, req_pending);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (lights !== 8'h00 || active_dir !== 2'd3 || req_pending !== 4'h0 || phase_change !== 1'b0) begin
         bad++;
         $display("FAIL async_reset lights=%02h dir=%0d req=%h pc=%b expected lights=00 dir=3 req=0 pc=0",
                  lights, active_dir, req_pending, phase_change);
      end else begin
         $display("async reset lights=%02h dir=%0d req=%h ok", lights, active_dir, req_pending);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      prev_lights = 8'h00;
      tip = 0;
   endtask

   initial begin
      test_reset();
      test_gap_out();
      test_max_out();
      test_skip();
      test_freeze();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
